// File: rtl/seg7_pkg.sv
// Shared constants, types and helpers for the seven-segment display blocks.
// Every segment and anode pattern here is active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Bit order inside each pattern is seg[6:0] = {g,f,e,d,c,b,a}. Entry 0 is the rightmost element.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_t;

  function automatic int slot_cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Purely combinational hex nibble to active-low seven-segment decoder.
// Other display blocks reuse it.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver. A dark guard interval opens every slot.
// New content is staged in a pending register and swapped in only at frame boundaries.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100_000,
  parameter int GUARD_CYCLES = 1_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int              CW        = slot_cnt_width(REFRESH_DIV);
  localparam logic [CW-1:0]   SLOT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]   GUARD_END = CW'(GUARD_CYCLES);

  logic [CW-1:0] slot_cnt;
  logic [1:0]    digit_idx;
  disp_t         pending_q;
  disp_t         active_q;
  disp_t         load_data;
  logic          pending_valid;
  logic          slot_wrap;
  logic          boundary;
  logic [3:0]    cur_nibble;
  logic [6:0]    cur_seg;
  logic [6:0]    seg_d;
  logic [3:0]    an_d;
  logic          dp_d;

  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign boundary   = slot_wrap && (digit_idx == 2'd3);
  assign cur_nibble = active_q.digits[{digit_idx, 2'b00} +: 4];

  always_comb begin
    load_data        = '0;
    load_data.digits = digits_in;
    load_data.dp     = dp_in;
    load_data.blank  = blank_in;
  end

  hex_to_seg7 u_dec (
    .hex (cur_nibble),
    .seg (cur_seg)
  );

  // Scan position: slot_cnt runs through one slot, and digit_idx advances when a slot wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_wrap) begin
      slot_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      slot_cnt  <= slot_cnt + CW'(1);
    end
  end

  // load is a fire-and-forget strobe with no ready signal. Each edge with load=1 overwrites
  // pending unconditionally, so the last load wins. A load on the boundary edge replaces
  // pending while active takes the previous pending value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q     <= '0;
      pending_valid <= 1'b0;
      active_q      <= '{digits: 16'h0000, dp: 4'h0, blank: 4'hF};
      frame_start   <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (boundary && pending_valid)
        active_q <= pending_q;
      if (load) begin
        pending_q     <= load_data;
        pending_valid <= 1'b1;
      end else if (boundary) begin
        pending_valid <= 1'b0;
      end
    end
  end

  // The guard interval at the start of each slot means an anode always returns to AN_OFF
  // before the next anode is enabled.
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = AN_OFF;
    dp_d  = 1'b1;
    if ((slot_cnt >= GUARD_END) && !active_q.blank[digit_idx]) begin
      an_d  = ~(4'b0001 << digit_idx);
      seg_d = cur_seg;
      dp_d  = ~active_q.dp[digit_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_BLANK;
      an  <= AN_OFF;
      dp  <= 1'b1;
    end else begin
      seg <= seg_d;
      an  <= an_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=8 and GUARD_CYCLES=2 (32-cycle frame).
// cyc counts rising edges since reset release; the edges with cyc%32==0 are frame boundaries.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .REFRESH_DIV  (8),
    .GUARD_CYCLES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .load        (load),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_dark_reset();
    chk("rst_an",  16'(an),          16'h000F);
    chk("rst_seg", 16'(seg),         16'h007F);
    chk("rst_dp",  16'(dp),          16'h0001);
    chk("rst_fs",  16'(frame_start), 16'h0000);
  endtask

  // Advance one edge and sample 1 time unit later. Clearing load here keeps every load one cycle wide.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    load = 1'b0;
  endtask

  task automatic step_check(input logic [3:0] ea, input logic [6:0] es, input logic ed);
    logic efs;
    step();
    efs = ((cyc % 32) == 0);
    chk("an",          16'(an),          16'(ea));
    chk("seg",         16'(seg),         16'(es));
    chk("dp",          16'(dp),          16'(ed));
    chk("frame_start", 16'(frame_start), 16'(efs));
  endtask

  task automatic run_dark(input int n);
    repeat (n) step_check(4'hF, 7'h7F, 1'b1);
  endtask

  task automatic run_slot(input logic [3:0] ea, input logic [6:0] es, input logic ed);
    run_dark(2);
    repeat (6) step_check(ea, es, ed);
  endtask

  task automatic run_frame(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3);
    run_slot(4'b1110, s0, 1'b1);
    run_slot(4'b1101, s1, 1'b1);
    run_slot(4'b1011, s2, 1'b1);
    run_slot(4'b0111, s3, 1'b1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    digits_in = d;
    dp_in     = p;
    blank_in  = b;
    load      = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    load      = 1'b0;
    digits_in = '0;
    dp_in     = '0;
    blank_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_dark_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;

    // Three frames with nothing loaded: the display is dark and frame_start pulses every 32 cycles.
    run_dark(96);

    // Load 1234; it is shown only after the boundary at edge 128.
    do_load(16'h1234, 4'b0000, 4'b0000);
    run_dark(32);
    run_frame(7'h19, 7'h30, 7'h24, 7'h79);

    // Load ABCD with dp on digit 0 in the middle of a frame; the 1234 frame repeats first.
    do_load(16'hABCD, 4'b0001, 4'b0000);
    run_frame(7'h19, 7'h30, 7'h24, 7'h79);
    do_load(16'h1234, 4'b0000, 4'b0101);
    run_slot(4'b1110, 7'h21, 1'b0);
    run_slot(4'b1101, 7'h46, 1'b1);
    run_slot(4'b1011, 7'h03, 1'b1);
    run_slot(4'b0111, 7'h08, 1'b1);

    // Blank mask 0101: slots 0 and 2 stay dark. Two loads in the middle of this frame; the last one wins.
    do_load(16'h1111, 4'b0000, 4'b0000);
    run_dark(8);
    do_load(16'h2222, 4'b0000, 4'b0000);
    run_slot(4'b1101, 7'h30, 1'b1);
    run_dark(8);
    run_slot(4'b0111, 7'h79, 1'b1);

    // All digits show 2. 9999 is loaded mid-frame and 5678 on the boundary edge itself.
    do_load(16'h9999, 4'b0000, 4'b0000);
    run_slot(4'b1110, 7'h24, 1'b1);
    run_slot(4'b1101, 7'h24, 1'b1);
    run_slot(4'b1011, 7'h24, 1'b1);
    run_dark(2);
    repeat (5) step_check(4'b0111, 7'h24, 1'b1);
    do_load(16'h5678, 4'b0000, 4'b0000);
    step_check(4'b0111, 7'h24, 1'b1);
    run_frame(7'h10, 7'h10, 7'h10, 7'h10);
    run_frame(7'h00, 7'h78, 7'h02, 7'h12);

    // Assert reset in the middle of the slot that has an=1011; the outputs must go dark at once.
    run_slot(4'b1110, 7'h00, 1'b1);
    run_slot(4'b1101, 7'h78, 1'b1);
    run_dark(2);
    repeat (3) step_check(4'b1011, 7'h02, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_dark_reset();
    repeat (2) @(posedge clk);
    #1;
    check_dark_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    run_dark(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
